data_mem_resp: RTL
==================

Name: data_mem_resp

Overview:
- Data-memory responder for the CPU load/store bus: the target end of addr_bus, data_bus_out, mem_read, mem_wrt and data_bus_in.
- Holds a word array, inserts a configurable number of wait states and signals completion with a 4-phase ready handshake.
- Sits between the CPU data port and the word RAM; its rdata drives the CPU's data_bus_in.

Parameters:
- ADDR_W, 8, word-address width; array depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, wait states inserted between request capture and mem_ready; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mem_read  input  1  read request from the CPU; level, held until mem_ready is seen.
- mem_wrt  input  1  write request from the CPU; level, held until mem_ready is seen.
- addr  input  32  byte address from the CPU's addr_bus; word index = addr[ADDR_W+1:2].
- wdata  input  32  write data from the CPU's data_bus_out.
- rdata  output  32  read data to the CPU's data_bus_in; registered.
- mem_ready  output  1  transfer complete; registered.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - FSM goes to IDLE; rdata=0; mem_ready=0; wait counter=0.
  - Array contents are not cleared.
  - A transfer interrupted mid-operation is abandoned; a write that has not yet committed is never committed.
- FSM states: IDLE, WAIT, ACK, DROP.
- IDLE:
  - On a rising edge with mem_read|mem_wrt=1, capture addr, wdata, op and the word index into holding registers.
  - If WAIT_CYCLES=0, go to ACK; otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle; at counter=0 go to ACK.
  - Input changes in WAIT are ignored; the captured values are used.
- Entering ACK (same edge):
  - mem_ready<=1.
  - A captured write stores wdata to array[index].
  - A captured read loads rdata<=array[index].
- Latency: mem_ready rises exactly WAIT_CYCLES+1 rising edges after the capture edge.
- ACK:
  - mem_ready stays 1 and rdata stays stable while the request is held.
  - When mem_read=mem_wrt=0, clear mem_ready to 0 and go to IDLE.
- DROP is entered only from ACK when the request stays high for more than 16 cycles.
  - mem_ready goes to 0 in DROP.
  - The FSM waits for both requests low, then returns to IDLE.
  - This prevents a stuck master from retriggering the same access.
- A new request is accepted no earlier than one cycle after mem_ready falls. A held request is never executed twice.
- Simultaneous mem_read=mem_wrt=1 at capture: treated as a write; rdata is unchanged.
- rdata holds its last read value through writes and IDLE; it changes only on entry to ACK for a read.
- Addresses above the array range wrap on the ADDR_W index bits. addr[1:0] are ignored unless the fault feature is compiled in.

Optional Feature:
- Macro: DMEM_FAULT_EN.
- Defined:
  - Adds output mem_fault (1 bit, reset 0), asserted together with mem_ready when the captured access has any of: addr[1:0]!=0, addr[31:ADDR_W+2]!=0, or mem_read=mem_wrt=1.
  - A faulting write does not modify the array.
  - A faulting read returns rdata=32'hDEAD_BEEF.
  - mem_fault clears with mem_ready.
- Undefined: no mem_fault port; all accesses proceed as described under Behaviour.

Test Plan:
- Reset then write/read: write 32'h1234_5678 to addr 0x10, then read addr 0x10 -> mem_ready rises 3 edges after each capture (WAIT_CYCLES=2); rdata=32'h1234_5678.
- WAIT_CYCLES=0: read request on cycle N -> mem_ready=1 at edge N+1; drop the request -> mem_ready=0 the next edge, FSM back in IDLE.
- Held request: keep mem_wrt=1 for 40 cycles with changing wdata -> exactly one write commits (the captured value); mem_ready falls after 16 cycles in ACK; no second access occurs until the request drops.
- Reset mid-transfer: assert rst_n=0 during WAIT of a write of 32'hAAAA_AAAA to 0x20 -> mem_ready=0 and rdata=0 immediately; a subsequent read of 0x20 returns the old contents.
- Wrap and simultaneous requests (ADDR_W=8): write 32'h0F0F_0F0F to 0x400, read 0x000 -> rdata=32'h0F0F_0F0F. mem_read=mem_wrt=1 performs a write.
- DMEM_FAULT_EN: read of addr 0x13 -> mem_fault=1 with mem_ready, rdata=32'hDEAD_BEEF. Write to 0x13 leaves array[4] unchanged.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-array target for the CPU load/store bus, WAIT_CYCLES wait states, 4-phase mem_ready handshake.
// Optional: define DMEM_FAULT_EN to add o_mem_fault for misaligned, out-of-range or read+write accesses.
module data_mem_resp #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_wrt,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_mem_ready
`ifdef DMEM_FAULT_EN
  ,
  output logic        o_mem_fault
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DROP} state_t;

  localparam int          DEPTH      = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [3:0]  ACK_LIMIT  = 4'd15;
  localparam logic [31:0] FAULT_DATA = 32'hDEAD_BEEF;

  state_t            r_state;
  logic [3:0]        r_waitCnt;
  logic [3:0]        r_ackCnt;
  logic [ADDR_W-1:0] r_index;
  logic [31:0]       r_wdata;
  logic              r_isWrite;
  logic              r_fault;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req;
  logic              w_reqFault;
  logic              w_enterAck;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_index;

  assign w_req   = i_mem_read | i_mem_wrt;
  assign w_index = i_addr[ADDR_W+1:2];

`ifdef DMEM_FAULT_EN
  assign w_reqFault = (i_addr[1:0] != 2'b00) |
                      (i_addr[31:ADDR_W+2] != '0) |
                      (i_mem_read & i_mem_wrt);
`else
  logic [31-ADDR_W:0] w_unusedAddr;
  assign w_unusedAddr = {i_addr[31:ADDR_W+2], i_addr[1:0]};
  assign w_reqFault   = 1'b0;
`endif

  assign w_enterAck = (r_state == S_WAIT) && (r_waitCnt == 4'd0);
  assign w_memWe    = w_enterAck & r_isWrite & ~r_fault;

  // The array has no reset; a write only commits on the edge that enters ACK.
  always_ff @(posedge i_clk) begin
    if (w_memWe) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  // Capture always passes through WAIT so mem_ready lands WAIT_CYCLES+1 edges after capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_waitCnt   <= 4'd0;
      r_ackCnt    <= 4'd0;
      r_index     <= '0;
      r_wdata     <= 32'd0;
      r_isWrite   <= 1'b0;
      r_fault     <= 1'b0;
      o_rdata     <= 32'd0;
      o_mem_ready <= 1'b0;
`ifdef DMEM_FAULT_EN
      o_mem_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_index   <= w_index;
            r_wdata   <= i_wdata;
            r_isWrite <= i_mem_wrt;
            r_fault   <= w_reqFault;
            r_waitCnt <= WAIT_LOAD;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_waitCnt == 4'd0) begin
            r_state     <= S_ACK;
            r_ackCnt    <= 4'd0;
            o_mem_ready <= 1'b1;
`ifdef DMEM_FAULT_EN
            o_mem_fault <= r_fault;
`endif
            if (!r_isWrite) begin
              o_rdata <= r_fault ? FAULT_DATA : r_mem[r_index];
            end
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!w_req) begin
            o_mem_ready <= 1'b0;
`ifdef DMEM_FAULT_EN
            o_mem_fault <= 1'b0;
`endif
            r_state     <= S_IDLE;
          end else if (r_ackCnt == ACK_LIMIT) begin
            // A master that never releases gets ready withdrawn, not a repeat access.
            o_mem_ready <= 1'b0;
`ifdef DMEM_FAULT_EN
            o_mem_fault <= 1'b0;
`endif
            r_state     <= S_DROP;
          end else begin
            r_ackCnt <= r_ackCnt + 4'd1;
          end
        end
        S_DROP: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
